// File: rtl/zero_detect_arbiter_if.sv
// ---------------------------------------------------------------------------
// zero_detect_arbiter_if
// Bundles the request, detector and response signals of zero_detect_arbiter.
//   req_valid/req_ready  per-requester request handshake (2 requesters)
//   req_data0/req_data1  operands of requester 0 (ALU) and 1 (CBZ)
//   det_value/det_zero   registered operand to, and result from, the detector
//   rsp_valid/rsp_ready  per-requester response handshake
//   rsp_zero             sampled zero flag carried with rsp_valid
//   busy                 arbiter is not idle
// slave modport: the arbiter side; master modport: requesters + detector.
// ---------------------------------------------------------------------------
interface zero_detect_arbiter_if #(
    parameter int unsigned WIDTH = 64
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [WIDTH-1:0] det_value;
    logic             det_zero;
    logic [1:0]       rsp_valid;
    logic             rsp_zero;
    logic [1:0]       rsp_ready;
    logic             busy;

    modport slave (
        input  req_valid, req_data0, req_data1, det_zero, rsp_ready,
        output req_ready, det_value, rsp_valid, rsp_zero, busy
    );

    modport master (
        output req_valid, req_data0, req_data1, det_zero, rsp_ready,
        input  req_ready, det_value, rsp_valid, rsp_zero, busy
    );
endinterface

// File: rtl/zero_detect_arbiter.sv
// ---------------------------------------------------------------------------
// zero_detect_arbiter
// Shares one combinational zero detector between two requesters using
// round-robin arbitration. The accepted operand is registered onto det_value,
// the detector is given SETTLE_CYCLES edges to settle, then det_zero is
// sampled and returned on the owner's response handshake.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      zero_detect_arbiter_if.slave (request/detector/response signals)
// ---------------------------------------------------------------------------
module zero_detect_arbiter #(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    zero_detect_arbiter_if.slave  bus
);
    localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             rr_last_q;
    logic [WIDTH-1:0] det_value_q;
    logic [1:0]       rsp_valid_q;
    logic             rsp_zero_q;

    logic             grant;
    logic             grant_vld;
    logic [1:0]       req_ready_c;
    logic             accept;
    logic             settle_done;
    logic             rsp_take;

    // Lone requester wins outright; on contention the one not served last wins.
    always_comb begin
        grant_vld = |bus.req_valid;
        grant     = bus.req_valid[1];
        if (&bus.req_valid) begin
            grant = ~rr_last_q;
        end
    end

    always_comb begin
        req_ready_c = '0;
        if ((state_q == IDLE) && grant_vld) begin
            req_ready_c[grant] = 1'b1;
        end
    end

    assign accept      = (state_q == IDLE) && grant_vld;
    assign settle_done = (state_q == SETTLE) && (cnt_q == CNT_LAST);
    assign rsp_take    = (state_q == RESPOND) && bus.rsp_ready[owner_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)      state_d = SETTLE;
            SETTLE:  if (settle_done) state_d = RESPOND;
            RESPOND: if (rsp_take)    state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            det_value_q <= '0;
            rsp_valid_q <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                det_value_q <= grant ? bus.req_data1 : bus.req_data0;
                owner_q     <= grant;
                rr_last_q   <= grant;
                cnt_q       <= CNT_LOAD;
            end
            if (state_q == SETTLE) begin
                cnt_q <= cnt_q - CNT_LAST;
            end
            if (settle_done) begin
                rsp_zero_q  <= bus.det_zero;
                rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            end
            if (rsp_take) begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.det_value = det_value_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_zero_detect_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zero_detect_arbiter
// Bench for zero_detect_arbiter: a SETTLE_CYCLES=2 instance for the main
// scenarios plus SETTLE_CYCLES=1 and 4 instances for latency. Each instance's
// det_zero comes from a zero detector on its own det_value.
// ---------------------------------------------------------------------------
module tb_zero_detect_arbiter;
    localparam int SC_MAIN = 2;

    typedef struct packed {
        logic [1:0] who;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    zero_detect_arbiter_if #(.WIDTH(64)) bus2 ();
    zero_detect_arbiter_if #(.WIDTH(64)) bus1 ();
    zero_detect_arbiter_if #(.WIDTH(64)) bus4 ();

    assign bus2.det_zero = ~|bus2.det_value;
    assign bus1.det_zero = ~|bus1.det_value;
    assign bus4.det_zero = ~|bus4.det_value;

    zero_detect_arbiter #(.WIDTH(64), .SETTLE_CYCLES(SC_MAIN)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2));
    zero_detect_arbiter #(.WIDTH(64), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    zero_detect_arbiter #(.WIDTH(64), .SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4));

    task automatic do_reset();
        reset_n = 1'b0;
        bus2.req_valid = '0; bus2.req_data0 = '0; bus2.req_data1 = '0; bus2.rsp_ready = '0;
        bus1.req_valid = '0; bus1.req_data0 = '0; bus1.req_data1 = '0; bus1.rsp_ready = '0;
        bus4.req_valid = '0; bus4.req_data0 = '0; bus4.req_data1 = '0; bus4.rsp_ready = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Waits for any rsp_valid on the main instance; lat counts edges waited.
    task automatic wait_rsp(output logic [1:0] v, output logic z, output int lat, output bit to);
        to = 1'b1; lat = 0; v = '0; z = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus2.rsp_valid != 2'b00) begin
                v = bus2.rsp_valid; z = bus2.rsp_zero; lat = i; to = 1'b0;
                break;
            end
        end
    endtask

    // One isolated request on the main instance, from IDLE to IDLE.
    task automatic run_one(input bit which, input logic [63:0] data, input string tag);
        logic [1:0] v, want_ready;
        logic       z;
        int         lat;
        bit         to;
        exp_t       e;
        want_ready = which ? 2'b10 : 2'b01;
        if (which) bus2.req_data1 = data; else bus2.req_data0 = data;
        bus2.req_valid = want_ready;
        sb.push_back('{who: want_ready, zero: (data == 64'd0)});
        #1;
        n_checks++;
        if (bus2.req_ready !== want_ready)
            $display("FAIL %s_ready: got %b expected %b", tag, bus2.req_ready, want_ready);
        @(posedge clk); #1;
        bus2.req_valid = '0;
        n_checks++;
        if (bus2.busy !== 1'b1 || bus2.det_value !== data) begin
            $display("FAIL %s_capture: busy %b det_value %h expected busy 1 det_value %h",
                     tag, bus2.busy, bus2.det_value, data);
            n_fail++;
        end
        wait_rsp(v, z, lat, to);
        e = sb.pop_front();
        n_checks++;
        if (to || v !== e.who || z !== e.zero) begin
            $display("FAIL %s_rsp: timeout %0d valid %b zero %b expected valid %b zero %b",
                     tag, to, v, z, e.who, e.zero);
            n_fail++;
        end
        n_checks++;
        if (lat != SC_MAIN) begin
            $display("FAIL %s_latency: got %0d expected %0d", tag, lat, SC_MAIN);
            n_fail++;
        end
        bus2.rsp_ready = want_ready;
        @(posedge clk); #1;
        bus2.rsp_ready = '0;
        n_checks++;
        if (bus2.rsp_valid !== 2'b00 || bus2.busy !== 1'b0) begin
            $display("FAIL %s_release: rsp_valid %b busy %b expected 00 0", tag, bus2.rsp_valid, bus2.busy);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus2.req_valid = '0; bus2.rsp_ready = '0;
        #1;
        n_checks++;
        if (bus2.rsp_valid !== 2'b00 || bus2.rsp_zero !== 1'b0 || bus2.busy !== 1'b0 ||
            bus2.det_value !== 64'd0 || bus2.req_ready !== 2'b00) begin
            $display("FAIL reset_state: rsp_valid %b rsp_zero %b busy %b det_value %h req_ready %b expected all zero",
                     bus2.rsp_valid, bus2.rsp_zero, bus2.busy, bus2.det_value, bus2.req_ready);
            n_fail++;
        end
        do_reset();
        n_checks++;
        if (bus1.busy !== 1'b0 || bus4.busy !== 1'b0 || bus1.rsp_valid !== 2'b00 || bus4.rsp_valid !== 2'b00) begin
            $display("FAIL reset_aux: busy %b/%b rsp_valid %b/%b expected 0/0 00/00",
                     bus1.busy, bus4.busy, bus1.rsp_valid, bus4.rsp_valid);
            n_fail++;
        end
    endtask

    task automatic test_req0_zero();
        run_one(1'b0, 64'd0, "req0_zero");
    endtask

    task automatic test_req1_nonzero();
        run_one(1'b1, 64'h8000_0000_0000_0000, "req1_msb");
        run_one(1'b1, 64'h0000_0000_0000_0001, "req1_lsb");
    endtask

    task automatic test_contention();
        logic [1:0] v;
        logic       z;
        int         lat;
        bit         to;
        exp_t       e;
        do_reset();
        bus2.req_data0 = 64'd0;
        bus2.req_data1 = 64'd5;
        bus2.req_valid = 2'b11;
        sb.push_back('{who: 2'b01, zero: 1'b1});
        sb.push_back('{who: 2'b10, zero: 1'b0});
        sb.push_back('{who: 2'b01, zero: 1'b1});
        #1;
        n_checks++;
        if (bus2.req_ready !== 2'b01) begin
            $display("FAIL contention_first_grant: got %b expected 01", bus2.req_ready);
            n_fail++;
        end
        for (int k = 0; k < 3; k++) begin
            wait_rsp(v, z, lat, to);
            e = sb.pop_front();
            n_checks++;
            if (to || v !== e.who || z !== e.zero || lat != SC_MAIN + 1) begin
                $display("FAIL contention_rsp%0d: timeout %0d valid %b zero %b lat %0d expected valid %b zero %b lat %0d",
                         k, to, v, z, lat, e.who, e.zero, SC_MAIN + 1);
                n_fail++;
            end
            bus2.rsp_ready = e.who;
            @(posedge clk); #1;
            bus2.rsp_ready = '0;
            if (k == 2) bus2.req_valid = '0;
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus2.busy !== 1'b0) begin
            $display("FAIL contention_idle: busy %b expected 0", bus2.busy);
            n_fail++;
        end
    endtask

    task automatic test_respond_hold();
        logic [1:0] v;
        logic       z;
        int         lat;
        bit         to;
        exp_t       e;
        bus2.req_data0 = 64'hdead_beef;
        bus2.req_valid = 2'b01;
        sb.push_back('{who: 2'b01, zero: 1'b0});
        @(posedge clk); #1;
        bus2.req_data1 = 64'd0;
        bus2.req_valid = 2'b10;
        wait_rsp(v, z, lat, to);
        e = sb.pop_front();
        n_checks++;
        if (to || v !== e.who || z !== e.zero || lat != SC_MAIN) begin
            $display("FAIL hold_rsp: timeout %0d valid %b zero %b lat %0d expected valid %b zero %b lat %0d",
                     to, v, z, lat, e.who, e.zero, SC_MAIN);
            n_fail++;
        end
        bus2.rsp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus2.rsp_valid !== 2'b01 || bus2.rsp_zero !== 1'b0 ||
                bus2.det_value !== 64'hdead_beef || bus2.req_ready !== 2'b00 || bus2.busy !== 1'b1) begin
                $display("FAIL hold_cycle%0d: rsp_valid %b rsp_zero %b det_value %h req_ready %b busy %b expected 01 0 deadbeef 00 1",
                         c, bus2.rsp_valid, bus2.rsp_zero, bus2.det_value, bus2.req_ready, bus2.busy);
                n_fail++;
            end
        end
        bus2.rsp_ready = 2'b01;
        sb.push_back('{who: 2'b10, zero: 1'b1});
        @(posedge clk); #1;
        bus2.rsp_ready = '0;
        wait_rsp(v, z, lat, to);
        bus2.req_valid = '0;
        e = sb.pop_front();
        n_checks++;
        if (to || v !== e.who || z !== e.zero || lat != SC_MAIN + 1) begin
            $display("FAIL hold_next_rsp: timeout %0d valid %b zero %b lat %0d expected valid %b zero %b lat %0d",
                     to, v, z, lat, e.who, e.zero, SC_MAIN + 1);
            n_fail++;
        end
        bus2.rsp_ready = 2'b10;
        @(posedge clk); #1;
        bus2.rsp_ready = '0;
        n_checks++;
        if (bus2.busy !== 1'b0) begin
            $display("FAIL hold_idle: busy %b expected 0", bus2.busy);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus2.req_data0 = 64'h1234;
        bus2.req_valid = 2'b01;
        @(posedge clk); #1;
        bus2.req_valid = '0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus2.rsp_valid !== 2'b00 || bus2.rsp_zero !== 1'b0 || bus2.busy !== 1'b0 ||
            bus2.det_value !== 64'd0 || bus2.req_ready !== 2'b00) begin
            $display("FAIL midreset_state: rsp_valid %b rsp_zero %b busy %b det_value %h req_ready %b expected all zero",
                     bus2.rsp_valid, bus2.rsp_zero, bus2.busy, bus2.det_value, bus2.req_ready);
            n_fail++;
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus2.rsp_valid != 2'b00 || bus2.busy != 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            $display("FAIL midreset_no_rsp: activity seen 1 expected 0");
            n_fail++;
        end
        run_one(1'b0, 64'd0, "midreset_next");
    endtask

    task automatic test_settle_latency();
        int         lat1, lat4;
        logic [1:0] v1, v4;
        logic       z1, z4;
        lat1 = 0; lat4 = 0; v1 = '0; v4 = '0; z1 = 1'b0; z4 = 1'b0;
        bus1.req_data0 = 64'd0;
        bus4.req_data0 = 64'h40;
        bus1.req_valid = 2'b01;
        bus4.req_valid = 2'b01;
        @(posedge clk); #1;
        bus1.req_valid = '0;
        bus4.req_valid = '0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (lat1 == 0 && bus1.rsp_valid != 2'b00) begin
                lat1 = i; v1 = bus1.rsp_valid; z1 = bus1.rsp_zero;
            end
            if (lat4 == 0 && bus4.rsp_valid != 2'b00) begin
                lat4 = i; v4 = bus4.rsp_valid; z4 = bus4.rsp_zero;
            end
        end
        n_checks++;
        if (lat1 != 1 || v1 !== 2'b01 || z1 !== 1'b1) begin
            $display("FAIL settle1: lat %0d valid %b zero %b expected lat 1 valid 01 zero 1", lat1, v1, z1);
            n_fail++;
        end
        n_checks++;
        if (lat4 != 4 || v4 !== 2'b01 || z4 !== 1'b0) begin
            $display("FAIL settle4: lat %0d valid %b zero %b expected lat 4 valid 01 zero 0", lat4, v4, z4);
            n_fail++;
        end
        bus1.rsp_ready = 2'b01;
        bus4.rsp_ready = 2'b01;
        @(posedge clk); #1;
        bus1.rsp_ready = '0;
        bus4.rsp_ready = '0;
        n_checks++;
        if (bus1.busy !== 1'b0 || bus4.busy !== 1'b0) begin
            $display("FAIL settle_release: busy %b/%b expected 0/0", bus1.busy, bus4.busy);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_req0_zero();
        test_req1_nonzero();
        test_contention();
        test_respond_hold();
        test_reset_mid();
        test_settle_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
